// File: rtl/sha256_job_ctrl.sv
// Job controller for simplified_sha256: streams a message into shared memory,
// starts the hasher, then reads back the 8-word digest as one 256-bit result.
module sha256_job_ctrl #(
    parameter int NUM_OF_WORDS = 20,
    parameter int DIGEST_WORDS = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [15:0]  message_addr,
    input  logic [15:0]  output_addr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    output logic         sha_start,
    input  logic         sha_done,
    output logic         mem_sel,
    output logic         mem_we,
    output logic [15:0]  mem_addr,
    output logic [31:0]  mem_write_data,
    input  logic [31:0]  mem_read_data,
    output logic [255:0] digest,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic         busy
);

    localparam int CW = $clog2(NUM_OF_WORDS + 1);
    localparam int RW = $clog2(DIGEST_WORDS + 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_READ,
        S_OUT
    } state_t;

    state_t        state;
    logic [CW-1:0] wcount;
    logic [RW-1:0] rd;
    logic          accept;

    assign in_ready = (state == S_LOAD) && !reset;
    assign accept   = in_valid && in_ready;
    assign busy     = (state != S_LOAD) || (wcount != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_LOAD;
            wcount         <= '0;
            rd             <= '0;
            sha_start      <= 1'b0;
            mem_sel        <= 1'b1;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            digest         <= '0;
            digest_valid   <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            sha_start <= 1'b0;
            unique case (state)
                S_LOAD: begin
                    if (accept) begin
                        mem_we         <= 1'b1;
                        mem_addr       <= message_addr + 16'(wcount);
                        mem_write_data <= in_data;
                        wcount         <= wcount + 1'b1;
                        if (wcount == CW'(NUM_OF_WORDS - 1)) begin
                            sha_start <= 1'b1;
                            state     <= S_START;
                        end
                    end
                end
                S_START: begin
                    mem_sel <= 1'b0;
                    state   <= S_WAIT_BUSY;
                end
                // done is a level: it must fall before a rise means completion
                S_WAIT_BUSY: begin
                    if (!sha_done) state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (sha_done) begin
                        mem_sel  <= 1'b1;
                        mem_addr <= output_addr;
                        rd       <= '0;
                        state    <= S_READ;
                    end
                end
                S_READ: begin
                    rd <= rd + 1'b1;
                    if (rd < RW'(DIGEST_WORDS - 1))
                        mem_addr <= output_addr + 16'(rd) + 16'd1;
                    if (rd != '0)
                        digest <= {digest[223:0], mem_read_data};
                    if (rd == RW'(DIGEST_WORDS)) begin
                        digest_valid <= 1'b1;
                        state        <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (digest_ready) begin
                        digest_valid <= 1'b0;
                        wcount       <= '0;
                        state        <= S_LOAD;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule
